if_fetch_unit: RTL and testbench

//  Instruction-fetch stage directly downstream of NPC: holds the architectural PC register, loads it from
//  NPC's next-PC output, and drives a req/gnt/rvalid instruction-memory port. Delivers {pc, inst, valid}

---
 rtl/if_fetch_unit.sv | 145 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: architectural PC, req/gnt/rvalid imem port and the IF/ID register.
// Optional feature: define IF_MISALIGN_TRAP_EN to trap misaligned next-PC loads instead of masking them.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc_in,
    input  logic        redirect,
    input  logic        stall,
    output logic [31:0] pc_out,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_inst,
    output logic        if_id_valid,
    output logic        if_misalign
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic [31:0] req_addr_q;
    logic [31:0] hold_inst;
    logic        kill;
    logic        hold_vld;
    logic        req_pend_q;
    logic        misalign_q;

    logic        npc_mis;
    logic [31:0] pc_ld_val;
    logic [31:0] pc_nxt;
    logic        deliver_wait;
    logic        deliver_hold;

`ifdef IF_MISALIGN_TRAP_EN
    assign npc_mis     = |npc_in[1:0];
    assign pc_ld_val   = npc_in;
    assign if_misalign = misalign_q;
`else
    logic unused_npc_lo;
    assign unused_npc_lo = ^npc_in[1:0];
    assign npc_mis       = 1'b0;
    assign pc_ld_val     = {npc_in[31:2], 2'b00};
    assign if_misalign   = 1'b0;
`endif

    assign pc_out = pc_q;

    always_comb begin
        deliver_wait = (state == S_WAIT) && imem_rvalid && !kill && !redirect && !stall;
        deliver_hold = (state == S_HOLD) && hold_vld && !redirect && !stall;
        pc_nxt       = (redirect || deliver_wait || deliver_hold) ? pc_ld_val : pc_q;
        imem_req     = 1'b0;
        imem_addr    = req_addr_q;
        case (state)
            // A request already on the bus stays up even if a trap was raised meanwhile.
            S_REQ:  imem_req = req_pend_q || !misalign_q;
            S_WAIT: begin
                // Back-to-back: issue the next fetch in the same cycle the data lands.
                imem_req  = deliver_wait && !npc_mis && !misalign_q;
                imem_addr = pc_ld_val;
            end
            default: imem_req = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pc_q        <= RESET_PC;
            req_addr_q  <= RESET_PC;
            hold_inst   <= NOP_INST;
            kill        <= 1'b0;
            hold_vld    <= 1'b0;
            req_pend_q  <= 1'b0;
            misalign_q  <= 1'b0;
            if_id_pc    <= RESET_PC;
            if_id_inst  <= NOP_INST;
            if_id_valid <= 1'b0;
        end else begin
            pc_q       <= pc_nxt;
            req_pend_q <= imem_req && !imem_gnt;
            // Address tracks the PC until a request is actually presented, then freezes until gnt.
            if (state != S_REQ || !imem_req)
                req_addr_q <= pc_nxt;

            if (redirect) begin
                if_id_valid <= 1'b0;
                if_id_inst  <= NOP_INST;
            end else if (deliver_wait || deliver_hold) begin
                if_id_pc    <= pc_q;
                if_id_inst  <= deliver_hold ? hold_inst : imem_rdata;
                if_id_valid <= 1'b1;
            end else if (!stall) begin
                if_id_valid <= 1'b0;
                if_id_inst  <= NOP_INST;
            end

            if (redirect)
                misalign_q <= npc_mis;
            else if ((deliver_wait || deliver_hold) && npc_mis)
                misalign_q <= 1'b1;

            case (state)
                S_IDLE: state <= S_REQ;
                S_REQ: begin
                    if (redirect && imem_req)
                        kill <= 1'b1;
                    if (imem_req && imem_gnt)
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (kill || redirect) begin
                            kill  <= 1'b0;
                            state <= S_REQ;
                        end else if (stall) begin
                            hold_inst <= imem_rdata;
                            hold_vld  <= 1'b1;
                            state     <= S_HOLD;
                        end else begin
                            state <= (imem_req && imem_gnt) ? S_WAIT : S_REQ;
                        end
                    end else if (redirect) begin
                        kill <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redirect || !stall) begin
                        hold_vld <= 1'b0;
                        state    <= S_REQ;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: fixed-latency imem model, PC+4 NPC model, hand-computed expectations.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] npc_in;
    logic        redirect;
    logic        stall;
    logic [31:0] pc_out;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_inst;
    logic        if_id_valid;
    logic        if_misalign;

    logic [31:0] redir_pc;
    logic        gnt_en;
    int          lat;
    int          cnt = 0;
    logic [31:0] p_addr = 32'h0;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk(clk), .rst(rst), .npc_in(npc_in), .redirect(redirect), .stall(stall),
        .pc_out(pc_out), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_id_pc(if_id_pc),
        .if_id_inst(if_id_inst), .if_id_valid(if_id_valid), .if_misalign(if_misalign)
    );

    // NPC model: sequential PC+4 unless a redirect target is being driven.
    assign npc_in = redirect ? redir_pc : pc_out + 32'd4;

    // imem model: data = 0xC000_0000 | addr, rvalid 'lat' cycles after gnt.
    assign imem_gnt    = gnt_en;
    assign imem_rvalid = (cnt == 1);
    assign imem_rdata  = 32'hC000_0000 | p_addr;

    always @(posedge clk) begin
        if (rst)
            cnt <= 0;
        else if (imem_req && imem_gnt) begin
            cnt    <= lat;
            p_addr <= imem_addr;
        end else if (cnt > 0)
            cnt <= cnt - 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; redirect = 1'b0; stall = 1'b0; redir_pc = 32'h0; gnt_en = 1'b1; lat = 1;
        repeat (3) @(negedge clk);
        chk("rst_pc_out", pc_out, 32'h0);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_valid", if_id_valid, 1'b0);
        chk("rst_if_id_pc", if_id_pc, 32'h0);
        chk("rst_inst", if_id_inst, NOP);
        chk("rst_misalign", if_misalign, 1'b0);

        // Streaming with a 1-cycle memory
        rst = 1'b0;
        step();
        chk("t1_req", imem_req, 1'b1);
        chk("t1_addr", imem_addr, 32'h0);
        step();
        step();
        chk("t1_pc0", if_id_pc, 32'h0);
        chk("t1_valid0", if_id_valid, 1'b1);
        chk("t1_inst0", if_id_inst, 32'hC000_0000);
        step();
        chk("t1_pc4", if_id_pc, 32'h4);
        step();
        chk("t1_pc8", if_id_pc, 32'h8);
        step();
        chk("t1_pcC", if_id_pc, 32'hC);
        chk("t1_pc_out", pc_out, 32'h10);

        // Stall for 3 cycles while 0x10 data lands
        stall = 1'b1; #1;
        chk("t2_noreq", imem_req, 1'b0);
        step();
        chk("t2_frz_pc", if_id_pc, 32'hC);
        chk("t2_frz_valid", if_id_valid, 1'b1);
        step();
        step();
        chk("t2_frz_pc3", if_id_pc, 32'hC);
        chk("t2_frz_inst", if_id_inst, 32'hC000_000C);
        chk("t2_pc_out", pc_out, 32'h10);
        chk("t2_noreq3", imem_req, 1'b0);
        stall = 1'b0;
        step();
        chk("t2_rel_pc", if_id_pc, 32'h10);
        chk("t2_rel_inst", if_id_inst, 32'hC000_0010);
        chk("t2_rel_valid", if_id_valid, 1'b1);
        chk("t2_next_req", imem_req, 1'b1);
        chk("t2_next_addr", imem_addr, 32'h14);

        // Redirect while waiting on a slow fetch of 0x20
        step(); step(); step();
        chk("t3_pc18", if_id_pc, 32'h18);
        chk("t3_addr20", imem_addr, 32'h20);
        lat = 3;
        step();
        chk("t3_pc1C", if_id_pc, 32'h1C);
        chk("t3_pc_out20", pc_out, 32'h20);
        redirect = 1'b1; redir_pc = 32'h100;
        step();
        chk("t3_pc_out", pc_out, 32'h100);
        chk("t3_flush_valid", if_id_valid, 1'b0);
        chk("t3_flush_inst", if_id_inst, NOP);
        chk("t3_noreq", imem_req, 1'b0);
        redirect = 1'b0;
        step();
        chk("t3_drop_req", imem_req, 1'b0);
        chk("t3_drop_valid", if_id_valid, 1'b0);
        step();
        chk("t3_refetch_req", imem_req, 1'b1);
        chk("t3_refetch_addr", imem_addr, 32'h100);
        chk("t3_drop_valid2", if_id_valid, 1'b0);
        lat = 1;
        step(); step();
        chk("t3_pc100", if_id_pc, 32'h100);
        chk("t3_inst100", if_id_inst, 32'hC000_0100);
        chk("t3_valid100", if_id_valid, 1'b1);

        // Redirect and stall together
        redirect = 1'b1; redir_pc = 32'h200; stall = 1'b1;
        step();
        chk("t4_pc_out", pc_out, 32'h200);
        chk("t4_valid", if_id_valid, 1'b0);
        chk("t4_inst", if_id_inst, NOP);
        redirect = 1'b0; stall = 1'b0; #1;
        chk("t4_req", imem_req, 1'b1);
        chk("t4_addr", imem_addr, 32'h200);

        // Redirect to 0x40 as 0x200 is granted, then gnt low 4 cycles
        redirect = 1'b1; redir_pc = 32'h40;
        step();
        redirect = 1'b0; gnt_en = 1'b0; #1;
        chk("t5_pc_out", pc_out, 32'h40);
        chk("t5_kill_noreq", imem_req, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("t5_req_c%0d", i), imem_req, 1'b1);
            chk($sformatf("t5_addr_c%0d", i), imem_addr, 32'h40);
        end
        gnt_en = 1'b1;
        step(); step();
        chk("t5_pc40", if_id_pc, 32'h40);
        chk("t5_inst40", if_id_inst, 32'hC000_0040);

        // PC wraps from 0xFFFF_FFFC to 0
        redirect = 1'b1; redir_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0; #1;
        chk("w_pc_out", pc_out, 32'hFFFF_FFFC);
        chk("w_addr", imem_addr, 32'hFFFF_FFFC);
        step();
        chk("w_req0", imem_req, 1'b1);
        chk("w_addr0", imem_addr, 32'h0);
        step();
        chk("w_if_id_pc", if_id_pc, 32'hFFFF_FFFC);
        chk("w_inst", if_id_inst, 32'hFFFF_FFFC);
        chk("w_pc_out0", pc_out, 32'h0);

        // Misaligned redirect target
        redirect = 1'b1; redir_pc = 32'h102;
        step();
        redirect = 1'b0; #1;
`ifdef IF_MISALIGN_TRAP_EN
        chk("m_flag", if_misalign, 1'b1);
        chk("m_pc_out", pc_out, 32'h102);
        chk("m_noreq", imem_req, 1'b0);
        step(); step();
        chk("m_noreq2", imem_req, 1'b0);
        chk("m_sticky", if_misalign, 1'b1);
        chk("m_bubble", if_id_valid, 1'b0);
`else
        chk("m_flag", if_misalign, 1'b0);
        chk("m_pc_out", pc_out, 32'h100);
        chk("m_req", imem_req, 1'b1);
        chk("m_addr", imem_addr, 32'h100);
`endif

        // Reset mid-stream
        rst = 1'b1;
        step();
        chk("r2_pc_out", pc_out, 32'h0);
        chk("r2_valid", if_id_valid, 1'b0);
        chk("r2_req", imem_req, 1'b0);
        chk("r2_misalign", if_misalign, 1'b0);
        chk("r2_inst", if_id_inst, NOP);
        rst = 1'b0;
        step();
        chk("r2_req_after", imem_req, 1'b1);
        chk("r2_addr_after", imem_addr, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
